multdiv_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the iterative multiplier and divider units. It accepts a one-cycle MULT or DIV command from the pipeline and latches the operands. It then releases the selected unit from reset, waits for that unit's ready flag, and captures the result and exception. The held result is presented to the writeback stage with a single-cycle data_resultRDY pulse.

---
 rtl/multdiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the iterative multiplier and divider.
// Accepts a one-cycle MULT/DIV command and latches the operands. It then releases
// the selected unit from reset and waits for that unit's ready flag, or for a
// timeout. It captures the result and exception, then signals completion with a
// one-cycle pulse.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ctrl_MULT, ctrl_DIV           one-cycle command pulses (MULT wins if both high)
//   data_operandA/B               operands, sampled on a command pulse
//   data_result, data_exception   held result/exception of the last completed op
//   data_resultRDY                one-cycle completion pulse
//   busy                          high while an op is running or completing
//   unit_A, unit_B                latched operands to both units
//   mult_rst, div_rst             active-high unit resets
//   mult_ans/ovf/rdy              multiplier result, overflow, ready
//   div_ans/err/rdy               divider quotient, divide-by-zero error, ready
module multdiv_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [WIDTH-1:0] unit_A,
  output logic [WIDTH-1:0] unit_B,
  output logic             mult_rst,
  output logic             div_rst,
  input  logic [WIDTH-1:0] mult_ans,
  input  logic             mult_ovf,
  input  logic             mult_rdy,
  input  logic [WIDTH-1:0] div_ans,
  input  logic             div_err,
  input  logic             div_rdy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic {OpMult, OpDiv} op_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             cmd;
  logic             sel_rdy;
  logic             sel_exc;
  logic [WIDTH-1:0] sel_ans;

  assign cmd = ctrl_MULT | ctrl_DIV;

  // Only the selected unit's handshake matters; the other unit is held in reset.
  always_comb begin
    sel_rdy = mult_rdy;
    sel_exc = mult_ovf;
    sel_ans = mult_ans;
    if (op_q == OpDiv) begin
      sel_rdy = div_rdy;
      sel_exc = div_err;
      sel_ans = div_ans;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;

    case (state_q)
      StIdle: ;
      StRun: begin
        if (sel_rdy) begin
          result_d = sel_exc ? '0 : sel_ans;
          exc_d    = sel_exc;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A new command overrides everything: an in-flight op is abandoned without
    // touching the held result.
    if (cmd) begin
      opa_d    = data_operandA;
      opb_d    = data_operandB;
      op_d     = (ctrl_DIV && !ctrl_MULT) ? OpDiv : OpMult;
      cnt_d    = '0;
      state_d  = StRun;
      result_d = result_q;
      exc_d    = exc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q == StRun) || (state_q == StDone);
  assign unit_A         = opa_q;
  assign unit_B         = opb_q;
  // Derived from registered state, so a unit comes out of reset on the first RUN cycle.
  assign mult_rst       = rst | ~((state_q == StRun) && (op_q == OpMult));
  assign div_rst        = rst | ~((state_q == StRun) && (op_q == OpDiv));

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl. The multiplier and divider are stubbed by behavioural
// units with a programmable ready latency. A scoreboard queue holds the expected
// completion (cycle, result, exception) of each command, and a negedge monitor
// pops it when the pulse appears.
module tb_multdiv_ctrl;
  localparam int W  = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_MULT, ctrl_DIV;
  logic [W-1:0]  data_operandA, data_operandB;
  logic [W-1:0]  data_result;
  logic          data_exception, data_resultRDY, busy;
  logic [W-1:0]  unit_A, unit_B;
  logic          mult_rst, div_rst;
  logic [W-1:0]  mult_ans, div_ans;
  logic          mult_ovf, mult_rdy, div_err, div_rdy;

  always #5 clk = ~clk;

  multdiv_ctrl #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .unit_A         (unit_A),
    .unit_B         (unit_B),
    .mult_rst       (mult_rst),
    .div_rst        (div_rst),
    .mult_ans       (mult_ans),
    .mult_ovf       (mult_ovf),
    .mult_rdy       (mult_rdy),
    .div_ans        (div_ans),
    .div_err        (div_err),
    .div_rdy        (div_rdy)
  );

  // ---------------- unit stubs ----------------
  int mult_lat = 5;
  int div_lat  = 5;
  int mcnt = 0;
  int dcnt = 0;
  longint mprod, dquo;

  always @(posedge clk) begin
    if (mult_rst) mcnt <= 0; else mcnt <= mcnt + 1;
    if (div_rst)  dcnt <= 0; else dcnt <= dcnt + 1;
  end

  always_comb begin
    mprod    = longint'($signed(unit_A)) * longint'($signed(unit_B));
    mult_ans = mprod[31:0];
    mult_ovf = (mprod > 64'sd2147483647) || (mprod < -64'sd2147483648);
    mult_rdy = !mult_rst && (mcnt >= mult_lat);
    dquo     = 0;
    if (unit_B == '0) begin
      div_ans = 32'hDEADBEEF;  // garbage: the controller must force 0
      div_err = 1'b1;
    end else begin
      dquo    = longint'($signed(unit_A)) / longint'($signed(unit_B));
      div_ans = dquo[31:0];
      div_err = 1'b0;
    end
    div_rdy = !div_rst && (dcnt >= div_lat);
  end

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    int         cyc;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_cmd = 0;
  int          end_cyc = 0;
  logic        m_op_div = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Completion seen from outside: the selected unit is ready k = lat+1 cycles after
  // the command; the pulse follows one cycle later. Past TIMEOUT run cycles the op
  // is forced to an exception with a zero result.
  function automatic void ref_op(input bit isdiv, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, output logic [31:0] r, output logic e,
                                 output int dur);
    longint p;
    int k;
    k = lat + 1;
    if (k > TO) begin
      r = '0; e = 1'b1; dur = TO + 1;
    end else begin
      dur = k + 1;
      if (isdiv) begin
        if (b == 0) begin
          r = '0; e = 1'b1;
        end else begin
          p = longint'($signed(a)) / longint'($signed(b));
          r = p[31:0]; e = 1'b0;
        end
      end else begin
        p = longint'($signed(a)) * longint'($signed(b));
        if (p != longint'($signed(p[31:0]))) begin
          r = '0; e = 1'b1;
        end else begin
          r = p[31:0]; e = 1'b0;
        end
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      bit run_exp, busy_exp;
      busy_exp = (cyc > last_cmd) && (cyc <= end_cyc);
      run_exp  = (cyc > last_cmd) && (cyc < end_cyc);
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("mult_rst", 32'(mult_rst), 32'(rst || !(run_exp && !m_op_div)));
      chk("div_rst", 32'(div_rst), 32'(rst || !(run_exp && m_op_div)));
      if (run_exp) begin
        chk("unit_A", unit_A, m_a);
        chk("unit_B", unit_B, m_b);
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_pulse cyc=%0d got=none exp=pulse@%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (data_resultRDY) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=pulse exp=%0s", cyc,
                   (sbq.size() == 0) ? "none" : $sformatf("pulse@%0d", sbq[0].cyc));
        end else begin
          exp_t it;
          it = sbq.pop_front();
          chk("data_result", data_result, it.res);
          chk("data_exception", 32'(data_exception), 32'(it.exc));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic issue(input bit do_mult, input bit do_div, input logic [31:0] a,
                       input logic [31:0] b);
    int          c, dur;
    bit          isdiv;
    logic [31:0] r;
    logic        e;
    isdiv         = do_div && !do_mult;
    c             = cyc;
    ctrl_MULT     = do_mult;
    ctrl_DIV      = do_div;
    data_operandA = a;
    data_operandB = b;
    step(1);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    // An op whose pulse would have come after this command is aborted.
    while (sbq.size() > 0 && sbq[$].cyc > c) void'(sbq.pop_back());
    ref_op(isdiv, a, b, isdiv ? div_lat : mult_lat, r, e, dur);
    sbq.push_back('{c + dur, r, e});
    last_cmd = c;
    end_cyc  = c + dur;
    m_op_div = isdiv;
    m_a      = a;
    m_b      = b;
  endtask

  task automatic do_reset();
    int r;
    r   = cyc;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    while (sbq.size() > 0 && sbq[$].cyc > r) void'(sbq.pop_back());
    if (end_cyc > r) end_cyc = r;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_rst", 32'(div_rst), 32'd1);
    chk("rst_mult_rst", 32'(mult_rst), 32'd1);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exception", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    int v;
    case ($urandom_range(0, 4))
      0:       v = int'($urandom_range(0, 200)) - 100;
      1:       v = int'($urandom);
      2:       v = 0;
      3:       v = int'($urandom_range(1, 9));
      default: v = int'($urandom_range(0, 70000)) - 35000;
    endcase
    return v;
  endfunction

  function automatic int rnd_lat();
    case ($urandom_range(0, 9))
      0:       return 1000;    // never ready
      1:       return TO - 1;  // ready on the last allowed cycle
      2:       return TO;      // one cycle too late
      default: return int'($urandom_range(0, 12));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    step(1);
    mon_en = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", 32'(data_exception), 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    chk("reset_unit_A", unit_A, 32'd0);
    chk("reset_unit_B", unit_B, 32'd0);
    step(2);

    // Directed cases.
    issue(1'b0, 1'b1, 32'd100, 32'd7);                wait_until(end_cyc + 2);
    issue(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);           wait_until(end_cyc + 2);
    issue(1'b1, 1'b0, 32'd6, 32'hFFFFFFF9);           wait_until(end_cyc + 2);
    issue(1'b0, 1'b1, 32'd5, 32'd0);                  wait_until(end_cyc + 2);
    issue(1'b0, 1'b1, 32'd9, 32'd3);                  wait_until(end_cyc + 2);
    div_lat = 30;
    t = cyc;
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    wait_until(t + 10);
    mult_lat = 3;
    issue(1'b1, 1'b0, 32'd3, 32'd4);                  wait_until(end_cyc + 2);
    issue(1'b1, 1'b1, 32'd2, 32'd5);                  wait_until(end_cyc + 2);
    mult_lat = 1000;
    issue(1'b1, 1'b0, 32'd7, 32'd8);                  wait_until(end_cyc + 2);
    mult_lat = TO - 1;
    issue(1'b1, 1'b0, 32'd3, 32'd5);                  wait_until(end_cyc + 2);
    mult_lat = TO;
    issue(1'b1, 1'b0, 32'd3, 32'd5);                  wait_until(end_cyc + 2);
    mult_lat = 2;
    issue(1'b1, 1'b0, 32'h00010000, 32'h00010000);    wait_until(end_cyc + 2);
    div_lat = 30;
    t = cyc;
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    wait_until(t + 5);
    do_reset();
    step(45);

    // Randomized: back-to-back issue in DONE, aborts onto the other unit, idle gaps.
    for (int i = 0; i < 80; i++) begin
      bit          abort, dm, dd;
      logic [31:0] a, b;
      abort = ($urandom_range(0, 3) == 0) && (end_cyc > cyc);
      if (abort) begin
        step($urandom_range(0, end_cyc - cyc - 1));
        // Switch units so the new unit really starts from reset.
        if (m_op_div) begin
          dm = 1'b1; dd = 1'($urandom_range(0, 1));
        end else begin
          dm = 1'b0; dd = 1'b1;
        end
      end else begin
        wait_until(end_cyc + $urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0:       begin dm = 1'b1; dd = 1'b0; end
          1:       begin dm = 1'b0; dd = 1'b1; end
          default: begin dm = 1'b1; dd = 1'b1; end
        endcase
      end
      a = rnd_operand();
      b = rnd_operand();
      if (dd && !dm) div_lat = rnd_lat(); else mult_lat = rnd_lat();
      issue(dm, dd, a, b);
    end

    wait_until(end_cyc + 3);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain cyc=%0d got=%0d_pending exp=0_pending", cyc, sbq.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
